// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle two's-complement adder that adds WIDTH-bit
// operands CHUNK bits per clock, least significant chunk first. The carry
// between chunks is held in a register.
// Start/done handshake. Results (sum, carryout, overflow, zero) are registered
// and are loaded on the edge that enters DONE.
// Optional feature: define SUBTRACT_EN to add the `sub` port (a - b = a + ~b + 1).
// WIDTH must be a multiple of CHUNK.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  // Operand shift registers: the current chunk always sits in the low CHUNK bits
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic [WIDTH-1:0] sum_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             zero_q;

  logic             sub_en;
  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   add_w;
  logic             cin_msb;
  logic [WIDTH-1:0] res_d;

`ifdef SUBTRACT_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  // A start is honoured only while no operation is in flight
  assign accept     = start && (state_q != RUN);
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // One CHUNK-bit add per cycle; this is the whole combinational path
  assign add_w = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  // Carry into the top bit of the chunk, recovered from the sum bit
  assign cin_msb = add_w[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  // New chunk enters at the top, so after NCHUNK shifts the result is aligned
  assign res_d = (res_q >> CHUNK) | (WIDTH'(add_w[CHUNK-1:0]) << (WIDTH - CHUNK));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, then shift one chunk per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= a;
      b_q     <= sub_en ? ~b : b;
      carry_q <= sub_en;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      res_q   <= res_d;
      carry_q <= add_w[CHUNK];
      k_q     <= k_q + KW'(1);
    end
  end

  // Result registers: loaded on the edge into DONE, held until next completion
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (state_q == RUN && last_chunk) begin
      sum_q      <= res_d;
      carryout_q <= add_w[CHUNK];
      overflow_q <= cin_msb ^ add_w[CHUNK];
      zero_q     <= (res_d == '0);
    end
  end

  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=32, CHUNK=8). Expected results
// are pushed when a start is driven and popped when done is observed.
module tb_chunked_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         sub;
  logic         busy, done, carryout, overflow, zero;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
`ifdef SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .carryout(carryout),
    .overflow(overflow),
    .zero(zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference model of one operation
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (x[W-1] == yy[W-1]) && (e.s[W-1] != x[W-1]);
    e.z  = (e.s == '0);
    return e;
  endfunction

  // Scoreboard: every done pops and compares one expected result
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sum", 64'(sum), 64'(e.s));
        check_eq("carryout", 64'(carryout), 64'(e.co));
        check_eq("overflow", 64'(overflow), 64'(e.ov));
        check_eq("zero", 64'(zero), 64'(e.z));
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    start = 1'b1;
    a     = x;
    b     = y;
`ifdef SUBTRACT_EN
    sub   = s;
    exp_q.push_back(model(x, y, s));
`else
    sub   = 1'b0;
    exp_q.push_back(model(x, y, 1'b0));
`endif
  endtask

  // Returns at the negedge of the cycle in which done is high
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(posedge clk); #1;
    drive_start(x, y, s);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_flags", 64'({carryout, overflow, zero}), 64'd0);

    // Basic add with cycle-exact timing
    @(posedge clk); #1;
    drive_start(32'h00000001, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    check_eq("t0_busy", 64'(busy), 64'd0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq($sformatf("t%0d_busy", cyc), 64'(busy), 64'(cyc <= 4));
      check_eq($sformatf("t%0d_done", cyc), 64'(done), 64'(cyc == 5));
    end

    // Cross-chunk carries and overflow
    op(32'hFFFBFFFF, 32'h00000001, 1'b0);
    op(32'h04000000, 32'hFFFFFFFF, 1'b0);
    op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    op(32'h80000000, 32'hFFFFFFFB, 1'b0);
    for (int i = 0; i < 4; i++) op($urandom, $urandom, 1'b0);

    // Start while busy is ignored
    @(posedge clk); #1;
    drive_start(32'h00000001, 32'h00000002, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 32'hDEADBEEF; b = 32'h11111111;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("ign_no_done", 64'(done), 64'd0);
      check_eq("ign_no_busy", 64'(busy), 64'd0);
    end

    // Back-to-back: start in the done cycle
    @(posedge clk); #1;
    drive_start(32'h00001234, 32'h00005678, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    drive_start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_busy%0d", i), 64'(busy), 64'(i <= 4));
      check_eq($sformatf("b2b_done%0d", i), 64'(done), 64'(i == 5));
    end

    // Leave non-zero flags so the reset clearing is visible
    op(32'h80000000, 32'hFFFFFFFB, 1'b0);

    // Reset in cycle 2 of an operation
    @(posedge clk); #1;
    drive_start(32'h0000FFFF, 32'h00000001, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_done", 64'(done), 64'd0);
    check_eq("mr_sum", 64'(sum), 64'd0);
    check_eq("mr_flags", 64'({carryout, overflow, zero}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("mr_no_done", 64'(done), 64'd0);
    end
    op(32'h00000003, 32'h00000004, 1'b0);

`ifdef SUBTRACT_EN
    op(32'h00000005, 32'h00000007, 1'b1);
    op(32'h80000000, 32'h00000001, 1'b1);
    op(32'h12345678, 32'h12345678, 1'b1);
    for (int i = 0; i < 3; i++) op($urandom, $urandom, 1'b1);
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
